// File: rtl/fpga_tick_divider_if.sv
// Divisor update channel of fpga_tick_divider: one valid/ready pair per channel
// with the divisors packed side by side, channel c at [c*CntWidth +: CntWidth].
interface fpga_tick_divider_if #(
    parameter int NumChan  = 2,
    parameter int CntWidth = 16
);
    logic [NumChan*CntWidth-1:0] div_i;
    logic [NumChan-1:0]          div_valid_i;
    logic [NumChan-1:0]          div_ready_o;

    modport master (output div_i, output div_valid_i, input  div_ready_o);
    modport slave  (input  div_i, input  div_valid_i, output div_ready_o);
endinterface

// File: rtl/fpga_tick_divider.sv
// Bank of NumChan programmable clock-enable dividers, each producing a square wave
// and a one-cycle tick per period; divisors change only at period boundaries.
//
// Per-channel update FSM:
//   state      | meaning
//   ST_READY   | no update held, div_ready_o=1, a legal divisor is taken as pending
//   ST_PENDING | accepted divisor waits for wrap, sync_i or disable before it is applied
module fpga_tick_divider #(
    parameter int NumChan    = 2,
    parameter int CntWidth   = 16,
    parameter int DefaultDiv = 50
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumChan-1:0]          en_i,
    input  logic                        sync_i,
    fpga_tick_divider_if.slave          upd,
    output logic [NumChan*CntWidth-1:0] active_div_o,
    output logic [NumChan-1:0]          clk_o,
    output logic [NumChan-1:0]          tick_o,
    output logic [NumChan-1:0]          err_o
);

    typedef enum logic {
        ST_READY   = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_e;

    localparam logic [CntWidth-1:0] ResetDiv = CntWidth'(DefaultDiv);
    localparam logic [CntWidth-1:0] MinDiv   = CntWidth'(2);
    localparam logic [CntWidth-1:0] One      = CntWidth'(1);

    logic [NumChan-1:0] ready_vec;

    assign upd.div_ready_o = ready_vec;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        upd_state_e          state_q;
        upd_state_e          state_d;
        logic [CntWidth-1:0] cnt_q;
        logic [CntWidth-1:0] div_q;
        logic [CntWidth-1:0] pend_q;
        logic [CntWidth-1:0] div_new;
        logic                clk_q;
        logic                tick_q;
        logic                err_q;
        logic                ready;
        logic                en;
        logic                sync_ch;
        logic                wrap;
        logic                accept;
        logic                offer_bad;
        logic                apply;

        assign div_new   = upd.div_i[c*CntWidth +: CntWidth];
        assign en        = en_i[c];
        assign sync_ch   = sync_i & en;
        assign wrap      = (cnt_q == div_q - One);
        assign accept    = ready & upd.div_valid_i[c] & (div_new >= MinDiv);
        assign offer_bad = ready & upd.div_valid_i[c] & (div_new < MinDiv);
        // A disabled channel has no period boundary to wait for, so apply at once.
        assign apply     = (state_q == ST_PENDING) & (~en | sync_ch | wrap);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= ST_READY;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_READY:   if (accept) state_d = ST_PENDING;
                ST_PENDING: if (apply)  state_d = ST_READY;
                default:    state_d = ST_READY;
            endcase
        end

        always_comb begin
            ready = (state_q == ST_READY);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q  <= '0;
                div_q  <= ResetDiv;
                pend_q <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (~en || sync_ch || wrap) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + One;
                end
                if (accept) begin
                    pend_q <= div_new;
                end
                if (apply) begin
                    div_q <= pend_q;
                end
                if (offer_bad) begin
                    err_q <= 1'b1;
                end
                // Outputs decode the current count against the divisor of this period.
                clk_q  <= en & (cnt_q < (div_q >> 1));
                tick_q <= en & wrap & ~sync_ch;
            end
        end

        assign ready_vec[c]                          = ready;
        assign active_div_o[c*CntWidth +: CntWidth] = div_q;
        assign clk_o[c]                              = clk_q;
        assign tick_o[c]                             = tick_q;
        assign err_o[c]                              = err_q;
    end

endmodule

// File: tb/tb_fpga_tick_divider.sv
// Directed bench for fpga_tick_divider: a divisor table swept on channel 0, then
// hand-written sequences for handshake timing, illegal divisors, sync and reset.
module tb_fpga_tick_divider;

    localparam int NC = 2;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     en;
    logic              sync;
    logic [NC*CW-1:0]  active_div;
    logic [NC-1:0]     div_clk;
    logic [NC-1:0]     tick;
    logic [NC-1:0]     err;

    fpga_tick_divider_if #(.NumChan(NC), .CntWidth(CW)) upd ();

    fpga_tick_divider #(
        .NumChan   (NC),
        .CntWidth  (CW),
        .DefaultDiv(50)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .sync_i      (sync),
        .upd         (upd),
        .active_div_o(active_div),
        .clk_o       (div_clk),
        .tick_o      (tick),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int div;
        int exp_high;
        int exp_low;
        int exp_first_tick;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint adiv(input int c);
        return longint'(active_div[c*CW +: CW]);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Offer a divisor while the channel is disabled; it lands one edge after acceptance.
    task automatic program_div(input int c, input int d);
        upd.div_i[c*CW +: CW] = CW'(d);
        upd.div_valid_i[c]    = 1'b1;
        step();
        upd.div_valid_i[c]    = 1'b0;
        step();
    endtask

    initial begin
        int high, low, first, ntick, t0, t1, coinc;

        vecs[0] = '{50, 25, 25, 50};
        vecs[1] = '{7, 3, 4, 7};
        vecs[2] = '{2, 1, 1, 2};
        vecs[3] = '{3, 1, 2, 3};
        vecs[4] = '{10, 5, 5, 10};

        rst             = 1'b1;
        en              = '0;
        sync            = 1'b0;
        upd.div_i       = '0;
        upd.div_valid_i = '0;
        step();
        step();
        rst = 1'b0;

        check("reset_active_div0", adiv(0), 50);
        check("reset_active_div1", adiv(1), 50);
        check("reset_ready", upd.div_ready_o, 2'b11);
        check("reset_clk_o", div_clk, 2'b00);
        check("reset_tick_o", tick, 2'b00);
        check("reset_err_o", err, 2'b00);

        // Divisor table on channel 0.
        for (int v = 0; v < 5; v++) begin
            en = '0;
            step();
            program_div(0, vecs[v].div);
            check("tbl_active_div", adiv(0), vecs[v].div);
            en[0] = 1'b1;
            high = 0; low = 0; first = -1; ntick = 0;
            for (int k = 1; k <= 2 * vecs[v].div; k++) begin
                step();
                if (k <= vecs[v].div) begin
                    if (div_clk[0]) high++;
                    else            low++;
                end
                if (tick[0]) begin
                    ntick++;
                    if (first < 0) first = k;
                end
            end
            check("tbl_high_cycles", high, vecs[v].exp_high);
            check("tbl_low_cycles", low, vecs[v].exp_low);
            check("tbl_first_tick", first, vecs[v].exp_first_tick);
            check("tbl_tick_count", ntick, 2);
            en[0] = 1'b0;
            step();
            check("tbl_disable_outputs", {div_clk[0], tick[0]}, 2'b00);
        end

        // Mid-period write of 10 at cnt=20 with D=50.
        en = '0;
        do_reset();
        en[0] = 1'b1;
        for (int k = 1; k <= 20; k++) step();
        check("mid_ready_before", upd.div_ready_o[0], 1);
        upd.div_i[0 +: CW] = CW'(10);
        upd.div_valid_i[0] = 1'b1;
        step();
        upd.div_valid_i[0] = 1'b0;
        check("mid_ready_dropped", upd.div_ready_o[0], 0);
        for (int k = 22; k <= 49; k++) step();
        check("mid_ready_held_low", upd.div_ready_o[0], 0);
        check("mid_div_unchanged", adiv(0), 50);
        upd.div_i[0 +: CW] = CW'(4);
        upd.div_valid_i[0] = 1'b1;
        step();
        upd.div_valid_i[0] = 1'b0;
        check("mid_apply_ready", upd.div_ready_o[0], 1);
        check("mid_apply_div", adiv(0), 10);
        check("mid_wrap_tick", tick[0], 1);
        step();
        check("mid_wrap_valid_ignored", adiv(0), 10);
        first = -1;
        for (int k = 52; k <= 61; k++) begin
            step();
            if (tick[0] && first < 0) first = k;
        end
        check("mid_new_period_tick", first, 60);

        // Illegal divisors on channel 1.
        upd.div_i[CW +: CW] = CW'(1);
        upd.div_valid_i[1]  = 1'b1;
        step();
        upd.div_valid_i[1]  = 1'b0;
        check("err_div1_err", err[1], 1);
        check("err_div1_ready", upd.div_ready_o[1], 1);
        check("err_div1_active", adiv(1), 50);
        upd.div_i[CW +: CW] = CW'(0);
        upd.div_valid_i[1]  = 1'b1;
        step();
        upd.div_valid_i[1]  = 1'b0;
        for (int k = 0; k < 5; k++) step();
        check("err_sticky", err, 2'b10);
        check("err_div0_active", adiv(1), 50);
        do_reset();
        check("err_cleared", err, 2'b00);

        // Two channels, offset phases, then sync aligned with a channel 0 wrap.
        en = '0;
        do_reset();
        program_div(1, 30);
        check("sync_ch1_div", adiv(1), 30);
        en[0] = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        en[1] = 1'b1;
        for (int k = 8; k <= 49; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_tick_suppressed", tick[0], 0);
        t0 = 0; t1 = 0; coinc = -1;
        for (int j = 1; j <= 150; j++) begin
            step();
            if (j == 1) check("sync_realign_clk", div_clk, 2'b11);
            if (tick[0]) t0++;
            if (tick[1]) t1++;
            if (tick == 2'b11 && coinc < 0) coinc = j;
        end
        check("sync_ch0_ticks", t0, 3);
        check("sync_ch1_ticks", t1, 5);
        check("sync_coincide", coinc, 150);

        // Reset with an update pending.
        en = '0;
        do_reset();
        en[0] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        upd.div_i[0 +: CW] = CW'(20);
        upd.div_valid_i[0] = 1'b1;
        step();
        upd.div_valid_i[0] = 1'b0;
        check("rst_pending_accepted", upd.div_ready_o[0], 0);
        for (int k = 0; k < 3; k++) step();
        do_reset();
        check("rst_mid_active", adiv(0), 50);
        check("rst_mid_ready", upd.div_ready_o, 2'b11);
        check("rst_mid_outputs", {div_clk, tick, err}, 0);
        first = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (tick[0] && first < 0) first = k;
        end
        check("rst_pending_dropped", first, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
